// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-requester command buffer, arbiter and sequencer for the
// 1K x 16 dual-port internal RAM (write port plus RD_LAT-latency read port).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rdN, wrN            requester N one-cycle read / write strobes
//   aN, dinN            requester N address and write data, taken with strobe
//   doutN               requester N read data, held until its next read
//   doneN               requester N one-cycle completion pulse
//   busyN               requester N has a buffered (pending or active) command
//   ram_wr_a/ram_data/ram_we   RAM write port
//   ram_rd_a/ram_q             RAM read port
//
// Build option: define DPRAM_ARB_RR_EN for round-robin tie-breaking using the
// last grant; without it requester 0 always wins a tie.
// RD_LAT must be 1..4 (the wait counter is 2 bits wide).
module dpram_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd0,
    input  logic        wr0,
    input  logic [9:0]  a0,
    input  logic [15:0] din0,
    output logic [15:0] dout0,
    output logic        done0,
    output logic        busy0,
    input  logic        rd1,
    input  logic        wr1,
    input  logic [9:0]  a1,
    input  logic [15:0] din1,
    output logic [15:0] dout1,
    output logic        done1,
    output logic        busy1,
    output logic [9:0]  ram_rd_a,
    output logic [9:0]  ram_wr_a,
    output logic [15:0] ram_data,
    output logic        ram_we,
    input  logic [15:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_CAP
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    // Requester inputs gathered into index-able form.
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [9:0]  req_a   [2];
    logic [15:0] req_din [2];

    assign req_rd     = {rd1, rd0};
    assign req_wr     = {wr1, wr0};
    assign req_a[0]   = a0;
    assign req_a[1]   = a1;
    assign req_din[0] = din0;
    assign req_din[1] = din1;

    state_t      state_q,   state_d;
    logic        gnt_q,     gnt_d;
    logic [1:0]  cnt_q,     cnt_d;

    // Command buffers: valid, op (1 = read), address, write data.
    logic [1:0]  buf_v_q,   buf_v_d;
    logic [1:0]  buf_rd_q,  buf_rd_d;
    logic [9:0]  buf_a_q   [2];
    logic [9:0]  buf_a_d   [2];
    logic [15:0] buf_dat_q [2];
    logic [15:0] buf_dat_d [2];

    logic [15:0] dout_q    [2];
    logic [15:0] dout_d    [2];
    logic [1:0]  done_q,    done_d;
    logic        ram_we_q,  ram_we_d;
    logic [9:0]  ram_wr_a_q, ram_wr_a_d;
    logic [9:0]  ram_rd_a_q, ram_rd_a_d;
    logic [15:0] ram_data_q, ram_data_d;

    logic        pick;

`ifdef DPRAM_ARB_RR_EN
    logic        last_q, last_d;

    // Tie goes to the requester that was not granted most recently.
    always_comb begin
        if (&buf_v_q) begin
            pick = ~last_q;
        end else begin
            pick = buf_v_q[1];
        end
    end
`else
    // Requester 1 only wins when requester 0 has nothing buffered.
    assign pick = ~buf_v_q[0];
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        buf_v_d    = buf_v_q;
        buf_rd_d   = buf_rd_q;
        buf_a_d    = buf_a_q;
        buf_dat_d  = buf_dat_q;
        dout_d     = dout_q;
        done_d     = 2'b00;
        ram_we_d   = 1'b0;
        ram_wr_a_d = ram_wr_a_q;
        ram_rd_a_d = ram_rd_a_q;
        ram_data_d = ram_data_q;
`ifdef DPRAM_ARB_RR_EN
        last_d     = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (|buf_v_q) begin
                    gnt_d = pick;
`ifdef DPRAM_ARB_RR_EN
                    last_d = pick;
`endif
                    if (buf_rd_q[pick]) begin
                        state_d    = READ_WAIT;
                        cnt_d      = 2'd0;
                        ram_rd_a_d = buf_a_q[pick];
                    end else begin
                        // Write strobe is registered, so it lands in WRITE.
                        state_d    = WRITE;
                        ram_we_d   = 1'b1;
                        ram_wr_a_d = buf_a_q[pick];
                        ram_data_d = buf_dat_q[pick];
                    end
                end
            end
            WRITE: begin
                state_d        = IDLE;
                done_d[gnt_q]  = 1'b1;
                buf_v_d[gnt_q] = 1'b0;
            end
            READ_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = READ_CAP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            READ_CAP: begin
                state_d        = IDLE;
                done_d[gnt_q]  = 1'b1;
                dout_d[gnt_q]  = ram_q;
                buf_v_d[gnt_q] = 1'b0;
            end
        endcase

        // A buffer freed this edge is already empty in the done cycle, so
        // the empty check alone also admits strobes arriving with done.
        for (int n = 0; n < 2; n++) begin
            if (!buf_v_q[n] && (req_rd[n] || req_wr[n])) begin
                buf_v_d[n]   = 1'b1;
                buf_rd_d[n]  = req_rd[n];
                buf_a_d[n]   = req_a[n];
                buf_dat_d[n] = req_din[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            cnt_q      <= 2'd0;
            buf_v_q    <= 2'b00;
            buf_rd_q   <= 2'b00;
            buf_a_q    <= '{default: '0};
            buf_dat_q  <= '{default: '0};
            dout_q     <= '{default: '0};
            done_q     <= 2'b00;
            ram_we_q   <= 1'b0;
            ram_wr_a_q <= 10'h000;
            ram_rd_a_q <= 10'h000;
            ram_data_q <= 16'h0000;
`ifdef DPRAM_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            buf_v_q    <= buf_v_d;
            buf_rd_q   <= buf_rd_d;
            buf_a_q    <= buf_a_d;
            buf_dat_q  <= buf_dat_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            ram_we_q   <= ram_we_d;
            ram_wr_a_q <= ram_wr_a_d;
            ram_rd_a_q <= ram_rd_a_d;
            ram_data_q <= ram_data_d;
`ifdef DPRAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign dout0    = dout_q[0];
    assign dout1    = dout_q[1];
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign busy0    = buf_v_q[0];
    assign busy1    = buf_v_q[1];
    assign ram_we   = ram_we_q;
    assign ram_wr_a = ram_wr_a_q;
    assign ram_rd_a = ram_rd_a_q;
    assign ram_data = ram_data_q;

endmodule
